// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register with an optional skid entry, synchronous flush
// and a saturating stall counter. All state advances on the falling clock edge.
module pipe_stage_reg #(
    parameter int WIDTH = 32,
    parameter int SKID  = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    logic             head_valid, head_valid_nx;
    logic [WIDTH-1:0] head_data, head_data_nx;
    logic             skid_valid, skid_valid_nx;
    logic [WIDTH-1:0] skid_data, skid_data_nx;
    logic             ready_q;
    logic             accept, deliver, stall_hit;

    // With SKID=1 the ready register always mirrors !skid_valid, so an accept
    // can never coincide with an occupied skid entry.
    always_comb begin
        in_ready = (SKID != 0) ? ready_q : (!head_valid || out_ready);
    end

    assign accept    = in_valid && in_ready;
    assign deliver   = head_valid && out_ready;
    assign stall_hit = head_valid && !out_ready;

    assign out_valid = head_valid;
    assign out_data  = head_data;
    assign occupancy = {1'b0, head_valid} + {1'b0, skid_valid};

    // NOTE: every variable gets its hold value first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        head_valid_nx = head_valid;
        head_data_nx  = head_data;
        skid_valid_nx = skid_valid;
        skid_data_nx  = skid_data;
        if (flush) begin
            head_valid_nx = 1'b0;
            head_data_nx  = '0;
            skid_valid_nx = 1'b0;
            skid_data_nx  = '0;
        end else if (SKID != 0) begin
            if (deliver) begin
                if (skid_valid) begin
                    head_data_nx  = skid_data;
                    skid_valid_nx = 1'b0;
                end else if (accept) begin
                    head_data_nx  = in_data;
                end else begin
                    head_valid_nx = 1'b0;
                end
            end else if (accept) begin
                if (!head_valid) begin
                    head_valid_nx = 1'b1;
                    head_data_nx  = in_data;
                end else begin
                    skid_valid_nx = 1'b1;
                    skid_data_nx  = in_data;
                end
            end
        end else begin
            if (accept) begin
                head_valid_nx = 1'b1;
                head_data_nx  = in_data;
            end else if (deliver) begin
                head_valid_nx = 1'b0;
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values of the others, independent of statement order.
    always_ff @(negedge clk) begin
        if (rst) begin
            // NOTE: payload registers are reset too, because out_data must read 0
            // after reset rather than stale data.
            head_valid <= 1'b0;
            head_data  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            ready_q    <= 1'b1;
            stall_cnt  <= '0;
        end else begin
            head_valid <= head_valid_nx;
            head_data  <= head_data_nx;
            skid_valid <= skid_valid_nx;
            skid_data  <= skid_data_nx;
            ready_q    <= !skid_valid_nx;
            // Flush leaves the counter alone; it saturates instead of wrapping.
            if (stall_hit && !(&stall_cnt)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: three configurations share one stimulus
// stream and are compared against a queue-level model plus a hand-written table.
module tb_pipe_stage_reg;

    logic         clk;
    logic         rst, in_valid, flush, out_ready;
    logic [255:0] in_data;

    logic         ir_a, ov_a, ir_b, ov_b, ir_c, ov_c;
    logic [31:0]  od_a;
    logic [7:0]   od_b;
    logic [255:0] od_c;
    logic [1:0]   occ_a, occ_b, occ_c;
    logic [15:0]  st_a, st_b;
    logic [3:0]   st_c;

    pipe_stage_reg #(.WIDTH(32), .SKID(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_a), .in_data(in_data[31:0]),
        .flush(flush), .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a),
        .occupancy(occ_a), .stall_cnt(st_a));

    pipe_stage_reg #(.WIDTH(8), .SKID(0), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_b), .in_data(in_data[7:0]),
        .flush(flush), .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b),
        .occupancy(occ_b), .stall_cnt(st_b));

    pipe_stage_reg #(.WIDTH(256), .SKID(1), .CNT_W(4)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_c), .in_data(in_data),
        .flush(flush), .out_valid(ov_c), .out_ready(out_ready), .out_data(od_c),
        .occupancy(occ_c), .stall_cnt(st_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-DUT views so the model loop can index them.
    logic         g_ir[3], g_ov[3];
    logic [255:0] g_od[3];
    logic [1:0]   g_occ[3];
    logic [31:0]  g_st[3];
    assign g_ir[0] = ir_a;  assign g_ir[1] = ir_b;  assign g_ir[2] = ir_c;
    assign g_ov[0] = ov_a;  assign g_ov[1] = ov_b;  assign g_ov[2] = ov_c;
    assign g_od[0] = 256'(od_a); assign g_od[1] = 256'(od_b); assign g_od[2] = od_c;
    assign g_occ[0] = occ_a; assign g_occ[1] = occ_b; assign g_occ[2] = occ_c;
    assign g_st[0] = 32'(st_a); assign g_st[1] = 32'(st_b); assign g_st[2] = 32'(st_c);

    int cfg_skid[3]  = '{1, 0, 1};
    int cfg_w[3]     = '{32, 8, 256};
    int cfg_cnt_w[3] = '{16, 16, 4};

    // Model: each stage is a FIFO of capacity 1+SKID, plus a stall tally.
    logic [255:0] m_q[3][2];
    int           m_n[3]    = '{0, 0, 0};
    int           m_cnt[3]  = '{0, 0, 0};
    bit           m_zero[3] = '{0, 0, 0};
    bit           m_init    = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] mask_of(input int w);
        return (256'(1) << w) - 256'(1);
    endfunction

    task automatic step(input bit v, input logic [255:0] d, input bit ordy, input bit fl, input bit r);
        bit rdy[3];
        int mx;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        #1;
        for (int k = 0; k < 3; k++) begin
            rdy[k] = (cfg_skid[k] != 0) ? (m_n[k] < 2) : (m_n[k] == 0 || ordy);
            if (m_init) check($sformatf("in_ready_pre[%0d]", k), 256'(g_ir[k]), 256'(rdy[k]));
        end
        @(negedge clk);
        #1;
        if (r) m_init = 1'b1;
        for (int k = 0; k < 3; k++) begin
            mx = (1 << cfg_cnt_w[k]) - 1;
            if (m_n[k] > 0 && !ordy && m_cnt[k] < mx) m_cnt[k]++;
            if (r) begin
                m_n[k] = 0; m_cnt[k] = 0; m_zero[k] = 1'b1;
            end else if (fl) begin
                m_n[k] = 0; m_zero[k] = 1'b1;
            end else begin
                if (m_n[k] > 0 && ordy) begin
                    m_q[k][0] = m_q[k][1];
                    m_n[k]--;
                end
                if (v && rdy[k]) begin
                    m_q[k][m_n[k]] = d & mask_of(cfg_w[k]);
                    m_n[k]++;
                    m_zero[k] = 1'b0;
                end
            end
            if (m_init) begin
                check($sformatf("out_valid[%0d]", k), 256'(g_ov[k]), 256'(m_n[k] > 0));
                check($sformatf("occupancy[%0d]", k), 256'(g_occ[k]), 256'(m_n[k]));
                check($sformatf("stall_cnt[%0d]", k), 256'(g_st[k]), 256'(m_cnt[k]));
                check($sformatf("in_ready_post[%0d]", k), 256'(g_ir[k]),
                      256'((cfg_skid[k] != 0) ? (m_n[k] < 2) : (m_n[k] == 0 || ordy)));
                if (m_n[k] > 0) check($sformatf("out_data[%0d]", k), g_od[k], m_q[k][0]);
                else if (m_zero[k]) check($sformatf("out_data_zero[%0d]", k), g_od[k], '0);
            end
        end
    endtask

    typedef struct {
        bit          v;
        logic [31:0] d;
        bit          ordy, fl, r;
        bit          e_ov;
        logic [31:0] e_od;
        bit          chk_d;
        logic [1:0]  e_occ;
        bit          e_ir;
        int          e_st;
    } tv_t;

    tv_t tv[16];

    initial begin
        logic [255:0] rd;
        int n_acc, n_deliv;
        bit pre_dv;
        logic [7:0] pre_od;

        // Backpressure, flush collision and reset mid-stall, expected for dut_a.
        tv[0]  = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 2'd0, 1'b1, 0};
        tv[1]  = '{1'b1, 32'h0A, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0A, 1'b1, 2'd1, 1'b1, 0};
        tv[2]  = '{1'b1, 32'h0B, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0A, 1'b1, 2'd2, 1'b0, 1};
        tv[3]  = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0A, 1'b1, 2'd2, 1'b0, 2};
        tv[4]  = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0A, 1'b1, 2'd2, 1'b0, 3};
        tv[5]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0B, 1'b1, 2'd1, 1'b1, 3};
        tv[6]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 2'd0, 1'b1, 3};
        tv[7]  = '{1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 1'b1, 32'h11, 1'b1, 2'd1, 1'b1, 3};
        tv[8]  = '{1'b1, 32'h22, 1'b0, 1'b0, 1'b0, 1'b1, 32'h11, 1'b1, 2'd2, 1'b0, 4};
        tv[9]  = '{1'b1, 32'h0C, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 2'd0, 1'b1, 4};
        tv[10] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 2'd0, 1'b1, 4};
        tv[11] = '{1'b1, 32'h33, 1'b1, 1'b0, 1'b0, 1'b1, 32'h33, 1'b1, 2'd1, 1'b1, 4};
        tv[12] = '{1'b1, 32'h44, 1'b0, 1'b0, 1'b0, 1'b1, 32'h33, 1'b1, 2'd2, 1'b0, 5};
        tv[13] = '{1'b1, 32'h99, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 2'd0, 1'b1, 0};
        tv[14] = '{1'b1, 32'h55, 1'b0, 1'b0, 1'b0, 1'b1, 32'h55, 1'b1, 2'd1, 1'b1, 0};
        tv[15] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 2'd0, 1'b1, 0};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;

        for (int i = 0; i < 16; i++) begin
            step(tv[i].v, 256'(tv[i].d), tv[i].ordy, tv[i].fl, tv[i].r);
            check($sformatf("tv%0d out_valid", i), 256'(ov_a), 256'(tv[i].e_ov));
            check($sformatf("tv%0d occupancy", i), 256'(occ_a), 256'(tv[i].e_occ));
            check($sformatf("tv%0d in_ready", i), 256'(ir_a), 256'(tv[i].e_ir));
            check($sformatf("tv%0d stall_cnt", i), 256'(st_a), 256'(tv[i].e_st));
            if (tv[i].chk_d) check($sformatf("tv%0d out_data", i), 256'(od_a), 256'(tv[i].e_od));
        end

        // Streaming at full rate: each word shows up on the edge that accepts it.
        for (int i = 1; i <= 100; i++) begin
            step(1'b1, 256'(i), 1'b1, 1'b0, 1'b0);
            check($sformatf("stream%0d data", i), 256'(od_a), 256'(i));
            check($sformatf("stream%0d occ", i), 256'(occ_a), 256'(1));
            check($sformatf("stream%0d stall", i), 256'(st_a), 256'(0));
        end
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Single-entry stage under toggling out_ready: nothing lost or repeated.
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        n_acc = 0;
        n_deliv = 0;
        for (int i = 0; i < 16; i++) begin
            bit ordy;
            ordy = (i % 2 == 0);
            pre_dv = ov_b && ordy;
            pre_od = od_b;
            if (m_n[1] == 0 || ordy) n_acc++;
            step(1'b1, 256'(8'h10 + 8'(n_acc - ((m_n[1] == 0 || ordy) ? 1 : 0))), ordy, 1'b0, 1'b0);
            if (pre_dv) begin
                check($sformatf("skid0 order%0d", n_deliv), 256'(pre_od), 256'(8'h10 + 8'(n_deliv)));
                n_deliv++;
            end
            check($sformatf("skid0 occ_bound%0d", i), 256'(occ_b <= 2'd1), 256'(1));
        end
        if (ov_b) begin
            check("skid0 last", 256'(od_b), 256'(8'h10 + 8'(n_deliv)));
            n_deliv++;
        end
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("skid0 count", 256'(n_deliv), 256'(n_acc));

        // Saturation of the 4-bit stall counter after 20 stalled edges.
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 256'(32'h77), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("saturate cnt_w4", 256'(st_c), 256'(15));
        check("stall cnt_w16", 256'(st_a), 256'(20));

        // Randomized traffic against the model, including flush and reset.
        for (int i = 0; i < 400; i++) begin
            for (int w = 0; w < 8; w++) rd[w*32 +: 32] = $urandom;
            step($urandom_range(0, 3) != 0, rd, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
